// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants and types for the FFT peak detector
// Purpose: magnitude width, default frame length, scan state encoding and the
//          result record carried from the scanner to the result register.
// Ports:   none (package).
package fft_pkg;

  localparam int FFT_MAG_WIDTH   = 21;
  localparam int FFT_LEN_DEFAULT = 1024;
  localparam int FFT_BIN_WIDTH   = 13;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

  typedef struct packed {
    logic [FFT_BIN_WIDTH-1:0] bin;
    logic [FFT_MAG_WIDTH-1:0] mag;
  } peak_result_t;

endpackage

// File: rtl/fft_peak_detector_if.sv
// rtl/fft_peak_detector_if.sv - magnitude stream in, peak result out
// Purpose: bundles the FFT magnitude beat stream and the valid/ready result port.
// Ports:   in_valid/in_sop/in_eop/in_mag (stream), peak_valid/peak_ready/
//          peak_bin/peak_mag (result). slave = detector, master = source/consumer.
interface fft_peak_detector_if #(
  parameter int DATA_WIDTH = fft_pkg::FFT_MAG_WIDTH,
  parameter int BIN_WIDTH  = fft_pkg::FFT_BIN_WIDTH
);
  logic                  in_valid;
  logic                  in_sop;
  logic                  in_eop;
  logic [DATA_WIDTH-1:0] in_mag;
  logic                  peak_valid;
  logic                  peak_ready;
  logic [BIN_WIDTH-1:0]  peak_bin;
  logic [DATA_WIDTH-1:0] peak_mag;

  modport slave (
    input  in_valid, in_sop, in_eop, in_mag, peak_ready,
    output peak_valid, peak_bin, peak_mag
  );

  modport master (
    output in_valid, in_sop, in_eop, in_mag, peak_ready,
    input  peak_valid, peak_bin, peak_mag
  );
endinterface

// File: rtl/fft_peak_detector_peak_result_reg.sv
// rtl/fft_peak_detector_peak_result_reg.sv - single-entry result holding register
// Purpose: holds one result behind a valid/ready handshake; a load while an
//          unaccepted result is held overwrites it and sets sticky overrun.
// Ports:   clk, reset, load/load_data (producer), ready (consumer),
//          valid/data (held result), overrun (sticky loss flag).
module peak_result_reg #(
  parameter type result_t = fft_pkg::peak_result_t
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    load,
  input  result_t load_data,
  input  logic    ready,
  output logic    valid,
  output result_t data,
  output logic    overrun
);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid   <= 1'b0;
      data    <= '0;
      overrun <= 1'b0;
    end else if (load) begin
      // A load in the same cycle as acceptance replaces a consumed result: no loss.
      data  <= load_data;
      valid <= 1'b1;
      if (valid && !ready) begin
        overrun <= 1'b1;
      end
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fft_peak_detector.sv
// rtl/fft_peak_detector.sv - per-frame peak bin finder on FFT magnitude stream
// Purpose: scans each frame, tracks the largest magnitude in bins
//          [MIN_BIN, FFT_LEN/2-1] (ties keep the lowest bin), and publishes
//          bin/magnitude through a single-entry valid/ready register.
// Ports:   clk, reset (sync, active high), bus (stream in / result out),
//          threshold (only with FFT_PEAK_THRESH_EN), frame_cnt, overrun, frame_err.
// Option:  FFT_PEAK_THRESH_EN - publish only when the peak reaches threshold.
module fft_peak_detector
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = FFT_MAG_WIDTH,
  parameter int FFT_LEN    = FFT_LEN_DEFAULT,
  parameter int BIN_WIDTH  = FFT_BIN_WIDTH,
  parameter int MIN_BIN    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  fft_peak_detector_if.slave    bus,
`ifdef FFT_PEAK_THRESH_EN
  input  logic [DATA_WIDTH-1:0] threshold,
`endif
  output logic [15:0]           frame_cnt,
  output logic                  overrun,
  output logic                  frame_err
);

  localparam logic [BIN_WIDTH-1:0] MIN_B     = BIN_WIDTH'(MIN_BIN);
  localparam logic [BIN_WIDTH-1:0] HALF_LAST = BIN_WIDTH'(FFT_LEN / 2 - 1);
  localparam logic [BIN_WIDTH-1:0] LAST_BIN  = BIN_WIDTH'(FFT_LEN - 1);

  typedef struct packed {
    logic [BIN_WIDTH-1:0]  bin;
    logic [DATA_WIDTH-1:0] mag;
  } result_t;

  scan_state_t           state, state_nxt;
  logic [BIN_WIDTH-1:0]  bin_cnt;
  logic [BIN_WIDTH-1:0]  max_bin;
  logic [DATA_WIDTH-1:0] max_mag;

  logic start_beat, scan_beat, end_good, err_evt;
  logic [BIN_WIDTH-1:0]  cur_bin;
  logic [DATA_WIDTH-1:0] cmp_max;
  logic                  upd_max;
  logic                  pass_thresh;
  result_t               res_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (bus.in_valid) begin
      case (state)
        IDLE: if (bus.in_sop) state_nxt = SCAN;
        SCAN: begin
          if (bus.in_sop) begin
            state_nxt = SCAN;
          end else if (bus.in_eop || bin_cnt == LAST_BIN) begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Per-beat strobes; sop always wins over eop, so a sop+eop beat opens a frame.
  always_comb begin
    start_beat = 1'b0;
    scan_beat  = 1'b0;
    end_good   = 1'b0;
    err_evt    = 1'b0;
    if (bus.in_valid) begin
      case (state)
        IDLE: begin
          if (bus.in_sop) begin
            start_beat = 1'b1;
            err_evt    = bus.in_eop;
          end
        end
        SCAN: begin
          if (bus.in_sop) begin
            start_beat = 1'b1;
            err_evt    = 1'b1;
          end else if (bus.in_eop) begin
            end_good = (bin_cnt == LAST_BIN);
            err_evt  = (bin_cnt != LAST_BIN);
          end else if (bin_cnt == LAST_BIN) begin
            // Next beat would be bin FFT_LEN: frame overran without eop.
            err_evt = 1'b1;
          end else begin
            scan_beat = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // A starting beat is bin 0 and compares against an empty (zero) maximum.
  assign cur_bin = start_beat ? '0 : bin_cnt;
  assign cmp_max = start_beat ? '0 : max_mag;
  assign upd_max = (cur_bin >= MIN_B) && (cur_bin <= HALF_LAST) && (bus.in_mag > cmp_max);

`ifdef FFT_PEAK_THRESH_EN
  assign pass_thresh = (max_mag >= threshold);
`else
  assign pass_thresh = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      bin_cnt   <= '0;
      max_bin   <= '0;
      max_mag   <= '0;
      frame_cnt <= '0;
      frame_err <= 1'b0;
    end else begin
      if (start_beat) begin
        bin_cnt <= BIN_WIDTH'(1);
      end else if (scan_beat) begin
        bin_cnt <= bin_cnt + 1'b1;
      end
      if (start_beat || scan_beat) begin
        if (upd_max) begin
          max_mag <= bus.in_mag;
          max_bin <= cur_bin;
        end else if (start_beat) begin
          max_mag <= '0;
          max_bin <= MIN_B;
        end
      end
      if (end_good) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (err_evt) begin
        frame_err <= 1'b1;
      end
    end
  end

  peak_result_reg #(
    .result_t (result_t)
  ) u_result (
    .clk       (clk),
    .reset     (reset),
    .load      (end_good && pass_thresh),
    .load_data ('{bin: max_bin, mag: max_mag}),
    .ready     (bus.peak_ready),
    .valid     (bus.peak_valid),
    .data      (res_q),
    .overrun   (overrun)
  );

  assign bus.peak_bin = res_q.bin;
  assign bus.peak_mag = res_q.mag;

endmodule

// File: tb/tb_fft_peak_detector.sv
// tb/tb_fft_peak_detector.sv - directed self-checking bench for fft_peak_detector
module tb_fft_peak_detector;
  import fft_pkg::*;

  localparam int DW = 21;
  localparam int BW = 13;
  localparam int N  = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [15:0] frame_cnt;
  logic overrun, frame_err;
`ifdef FFT_PEAK_THRESH_EN
  logic [DW-1:0] threshold = '0;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] frame_mag [N];

  fft_peak_detector_if #(.DATA_WIDTH(DW), .BIN_WIDTH(BW)) bus ();

  fft_peak_detector #(
    .DATA_WIDTH (DW),
    .FFT_LEN    (N),
    .BIN_WIDTH  (BW),
    .MIN_BIN    (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
`ifdef FFT_PEAK_THRESH_EN
    .threshold (threshold),
`endif
    .frame_cnt (frame_cnt),
    .overrun   (overrun),
    .frame_err (frame_err)
  );

  always #10 clk = ~clk;

  task automatic clear_frame();
    for (int i = 0; i < N; i++) frame_mag[i] = '0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_sop   = 1'b0;
    bus.in_eop   = 1'b0;
  endtask

  // Drives len beats of frame_mag; eop on the last beat when with_eop is set.
  // Leaves the last beat on the bus; caller follows with idle_cycle().
  task automatic send_frame(input int len, input bit with_eop, input bit gaps);
    for (int i = 0; i < len; i++) begin
      if (gaps && ($urandom_range(0, 1) == 1)) idle_cycle();
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_sop   = (i == 0);
      bus.in_eop   = with_eop && (i == len - 1);
      bus.in_mag   = frame_mag[i];
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++; if (bus.peak_valid !== 1'b0) begin n_fail++; $display("FAIL reset_peak_valid got %0b want 0", bus.peak_valid); end
    n_tests++; if (bus.peak_bin !== '0) begin n_fail++; $display("FAIL reset_peak_bin got %0d want 0", bus.peak_bin); end
    n_tests++; if (bus.peak_mag !== '0) begin n_fail++; $display("FAIL reset_peak_mag got %0d want 0", bus.peak_mag); end
    n_tests++; if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_frame_cnt got %0d want 0", frame_cnt); end
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %0b want 0", overrun); end
    n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err got %0b want 0", frame_err); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    clear_frame();
    frame_mag[5]  = 21'd100;
    frame_mag[12] = 21'd900;
    send_frame(N, 1'b1, 1'b0);
    // Sampled while the eop beat is still pending: no result yet.
    n_tests++; if (bus.peak_valid !== 1'b0) begin n_fail++; $display("FAIL basic_latency got %0b want 0", bus.peak_valid); end
    idle_cycle();
    n_tests++; if (bus.peak_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %0b want 1", bus.peak_valid); end
    n_tests++; if (bus.peak_bin !== 13'd5) begin n_fail++; $display("FAIL basic_bin got %0d want 5", bus.peak_bin); end
    n_tests++; if (bus.peak_mag !== 21'd100) begin n_fail++; $display("FAIL basic_mag got %0d want 100", bus.peak_mag); end
    n_tests++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL basic_frame_cnt got %0d want 1", frame_cnt); end
    bus.peak_ready = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.peak_valid !== 1'b0) begin n_fail++; $display("FAIL basic_accept_drop got %0b want 0", bus.peak_valid); end
    bus.peak_ready = 1'b0;
  endtask

  task automatic test_tie_dc();
    clear_frame();
    frame_mag[0] = 21'd5000;
    frame_mag[3] = 21'd40;
    frame_mag[6] = 21'd40;
    send_frame(N, 1'b1, 1'b0);
    idle_cycle();
    n_tests++; if (bus.peak_bin !== 13'd3) begin n_fail++; $display("FAIL tie_bin got %0d want 3", bus.peak_bin); end
    n_tests++; if (bus.peak_mag !== 21'd40) begin n_fail++; $display("FAIL tie_mag got %0d want 40", bus.peak_mag); end
    n_tests++; if (frame_cnt !== 16'd2) begin n_fail++; $display("FAIL tie_frame_cnt got %0d want 2", frame_cnt); end
    bus.peak_ready = 1'b1;
    @(negedge clk);
    bus.peak_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    clear_frame();
    frame_mag[4] = 21'd10;
    send_frame(N, 1'b1, 1'b0);
    clear_frame();
    frame_mag[7] = 21'd20;
    send_frame(N, 1'b1, 1'b0);
    idle_cycle();
    n_tests++; if (bus.peak_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid got %0b want 1", bus.peak_valid); end
    n_tests++; if (bus.peak_bin !== 13'd7) begin n_fail++; $display("FAIL b2b_bin got %0d want 7", bus.peak_bin); end
    n_tests++; if (bus.peak_mag !== 21'd20) begin n_fail++; $display("FAIL b2b_mag got %0d want 20", bus.peak_mag); end
    n_tests++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL b2b_overrun got %0b want 1", overrun); end
    n_tests++; if (frame_cnt !== 16'd4) begin n_fail++; $display("FAIL b2b_frame_cnt got %0d want 4", frame_cnt); end
    bus.peak_ready = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.peak_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_accept_drop got %0b want 0", bus.peak_valid); end
    bus.peak_ready = 1'b0;
  endtask

  task automatic test_gaps_and_short();
    clear_frame();
    frame_mag[6] = 21'd77;
    send_frame(N, 1'b1, 1'b1);
    idle_cycle();
    n_tests++; if (bus.peak_bin !== 13'd6) begin n_fail++; $display("FAIL gaps_bin got %0d want 6", bus.peak_bin); end
    n_tests++; if (bus.peak_mag !== 21'd77) begin n_fail++; $display("FAIL gaps_mag got %0d want 77", bus.peak_mag); end
    n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL gaps_frame_err got %0b want 0", frame_err); end
    bus.peak_ready = 1'b1;
    @(negedge clk);
    bus.peak_ready = 1'b0;
    clear_frame();
    frame_mag[3] = 21'd99;
    send_frame(10, 1'b1, 1'b0);
    idle_cycle();
    @(negedge clk);
    n_tests++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL short_frame_err got %0b want 1", frame_err); end
    n_tests++; if (bus.peak_valid !== 1'b0) begin n_fail++; $display("FAIL short_valid got %0b want 0", bus.peak_valid); end
    n_tests++; if (frame_cnt !== 16'd5) begin n_fail++; $display("FAIL short_frame_cnt got %0d want 5", frame_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    clear_frame();
    frame_mag[4] = 21'd300;
    send_frame(9, 1'b0, 1'b0);
    idle_cycle();
    reset = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.peak_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %0b want 0", bus.peak_valid); end
    n_tests++; if (bus.peak_bin !== '0) begin n_fail++; $display("FAIL midrst_bin got %0d want 0", bus.peak_bin); end
    n_tests++; if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL midrst_frame_cnt got %0d want 0", frame_cnt); end
    n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL midrst_overrun got %0b want 0", overrun); end
    n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL midrst_frame_err got %0b want 0", frame_err); end
    reset = 1'b0;
    @(negedge clk);
    clear_frame();
    frame_mag[3] = 21'd55;
    send_frame(N, 1'b1, 1'b0);
    idle_cycle();
    n_tests++; if (bus.peak_valid !== 1'b1) begin n_fail++; $display("FAIL clean_valid got %0b want 1", bus.peak_valid); end
    n_tests++; if (bus.peak_bin !== 13'd3) begin n_fail++; $display("FAIL clean_bin got %0d want 3", bus.peak_bin); end
    n_tests++; if (bus.peak_mag !== 21'd55) begin n_fail++; $display("FAIL clean_mag got %0d want 55", bus.peak_mag); end
    n_tests++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL clean_frame_cnt got %0d want 1", frame_cnt); end
    n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL clean_frame_err got %0b want 0", frame_err); end
    bus.peak_ready = 1'b1;
    @(negedge clk);
    bus.peak_ready = 1'b0;
  endtask

`ifdef FFT_PEAK_THRESH_EN
  task automatic test_threshold();
    threshold = 21'd50;
    clear_frame();
    frame_mag[3] = 21'd40;
    send_frame(N, 1'b1, 1'b0);
    idle_cycle();
    n_tests++; if (bus.peak_valid !== 1'b0) begin n_fail++; $display("FAIL thr_low_valid got %0b want 0", bus.peak_valid); end
    n_tests++; if (frame_cnt !== 16'd2) begin n_fail++; $display("FAIL thr_low_frame_cnt got %0d want 2", frame_cnt); end
    clear_frame();
    frame_mag[5] = 21'd60;
    send_frame(N, 1'b1, 1'b0);
    idle_cycle();
    n_tests++; if (bus.peak_valid !== 1'b1) begin n_fail++; $display("FAIL thr_high_valid got %0b want 1", bus.peak_valid); end
    n_tests++; if (bus.peak_mag !== 21'd60) begin n_fail++; $display("FAIL thr_high_mag got %0d want 60", bus.peak_mag); end
    n_tests++; if (frame_cnt !== 16'd3) begin n_fail++; $display("FAIL thr_high_frame_cnt got %0d want 3", frame_cnt); end
  endtask
`endif

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_sop     = 1'b0;
    bus.in_eop     = 1'b0;
    bus.in_mag     = '0;
    bus.peak_ready = 1'b0;
    test_reset();
    test_basic();
    test_tie_dc();
    test_back_to_back();
    test_gaps_and_short();
    test_reset_mid_frame();
`ifdef FFT_PEAK_THRESH_EN
    test_threshold();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_peak_detector.md
Name: fft_peak_detector

Overview:
- Sits directly downstream of the FFT wrapper and consumes its streaming magnitude output: fft_magnitude, sink_sop, sink_eop, sink_valid.
- Per frame, finds the largest magnitude bin in the positive-frequency half, excluding low bins (DC/offset residue).
- Publishes bin index, magnitude and frame count through a valid/ready result port to the control/readout logic.
- The scan never stalls, because the FFT cannot be backpressured; an unaccepted result is overwritten and the loss is flagged.

Parameters:
- DATA_WIDTH, 21, magnitude width; matches the FFT magnitude output.
- FFT_LEN, 1024, points per frame; power of two, 8..8192.
- BIN_WIDTH, 13, bin counter width; must satisfy 2^BIN_WIDTH >= FFT_LEN.
- MIN_BIN, 2, lowest bin eligible for a peak; bins below it are ignored.

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  magnitude beat valid
- in_sop  in  1  first bin of frame; qualified by in_valid
- in_eop  in  1  last bin of frame; qualified by in_valid
- in_mag  in  DATA_WIDTH  unsigned magnitude
- peak_valid  out  1  result available
- peak_ready  in  1  consumer accepts the result
- peak_bin  out  BIN_WIDTH  bin index of the maximum
- peak_mag  out  DATA_WIDTH  maximum magnitude
- frame_cnt  out  16  completed good frames, wraps at 65535
- overrun  out  1  sticky: a result was overwritten before acceptance
- frame_err  out  1  sticky: malformed frame seen

Behaviour:
- Reset: all outputs 0; state IDLE; bin counter and running max cleared. Reset mid-frame discards the partial frame.
- States:
  - IDLE: a beat with in_valid&in_sop moves to SCAN. That beat is bin 0; bin counter is set to 1. Non-sop beats are ignored.
  - SCAN: every in_valid beat increments the bin counter.
- Eligible beat: bin index in [MIN_BIN, FFT_LEN/2-1].
  - Update the running max when in_mag > max (strict compare).
  - Ties keep the lowest bin. All-zero frame yields bin MIN_BIN, mag 0.
- End of frame (in_valid&in_eop in SCAN):
  - If bin index == FFT_LEN-1: load the result registers, increment frame_cnt, assert peak_valid on the next cycle (latency 1 cycle after the eop beat), return to IDLE.
  - Otherwise: set frame_err, produce no result, return to IDLE.
- Malformed frames, all of which set frame_err:
  - in_sop inside SCAN: restart the scan at bin 0 with that beat.
  - Bin index reaching FFT_LEN without eop: abort to IDLE.
  - An eop beat carrying sop: treated as sop; a one-beat frame is an error unless FFT_LEN == 1, which is not allowed.
- Result handshake:
  - peak_valid holds until a cycle with peak_valid&peak_ready; it drops the next cycle unless a new result loads in the same cycle.
  - peak_bin and peak_mag are stable while peak_valid=1 and not accepted.
  - New result loads while peak_valid=1 and not accepted this cycle: overwrite, keep peak_valid=1, set overrun.
  - Load coinciding with acceptance: no overrun, new result shown.
- Beats with in_valid=0 are ignored in all states. in_sop/in_eop without in_valid are ignored.
- Arithmetic:
  - Magnitudes are unsigned compares.
  - Bin counter is BIN_WIDTH bits, compared against FFT_LEN/2 and FFT_LEN-1 constants.
  - frame_cnt wraps modulo 2^16.

Optional Feature:
- FFT_PEAK_THRESH_EN, when defined:
  - Adds input port threshold (DATA_WIDTH).
  - The result is published only if peak_mag >= threshold, sampled at the eop beat.
  - Frames below threshold still increment frame_cnt but do not assert peak_valid and cannot cause overrun.
- Undefined: the port is absent and every good frame publishes.

Decomposition:
- Shared package fft_pkg:
  - FFT_MAG_WIDTH = 21 and the default FFT_LEN constant.
  - State enum {IDLE, SCAN}.
  - Result struct {bin, mag}.
- One sub-module, peak_result_reg: a single-entry valid/ready holding register with overwrite and overrun detection. The top holds the FSM, bin counter and running max.

Test Plan:
- FFT_LEN=16, MIN_BIN=2, contiguous frame with magnitudes 0 except bin5=100, bin12=900 -> peak_bin=5, peak_mag=100 one cycle after eop; frame_cnt=1; bin12 is ignored because it is above FFT_LEN/2-1.
- Frame with bin0=5000, bin3=40, bin6=40 -> peak_bin=3, peak_mag=40 (DC excluded, tie keeps lowest bin).
- Two back-to-back frames with peaks bin4=10 then bin7=20, peak_ready=0 throughout -> result shows bin7/20, overrun=1, frame_cnt=2; raising peak_ready drops peak_valid next cycle.
- in_valid toggling 50% with random gaps, peak bin6=77 -> same result as contiguous; eop at bin 9 of a 16-point frame -> frame_err=1, no peak_valid.
- Reset asserted at bin 8 mid-frame, then a clean frame with bin3=55 -> all outputs 0 during reset; result bin3/55, frame_cnt=1, frame_err=0.
- FFT_PEAK_THRESH_EN, threshold=50: peak 40 -> no peak_valid, frame_cnt increments; next frame peak 60 -> peak_valid with mag 60.
